// File: rtl/cmd_reply_packer.sv
// Frames command-interpreter reply words into fixed 256-word inband packets on txclk:
// header, timestamp, buffered payload, then zero padding up to 256 words.
module cmd_reply_packer #(
  parameter logic [4:0] CHANNEL   = 5'h1F,
  parameter int         HOLDOFF   = 4,
  parameter int         MAX_WORDS = 252
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic [31:0] adc_time,
  input  logic        rx_WR,
  input  logic [15:0] rx_databus,
  input  logic        rx_WR_done,
  output logic        rx_WR_enabled,
  input  logic        out_have_space,
  output logic        out_wr,
  output logic [15:0] out_data,
  output logic        out_pkt_end
);

  localparam int          IW   = $clog2(HOLDOFF + 1);
  localparam logic [7:0]  MAXC = 8'(MAX_WORDS);
  localparam logic [IW-1:0] HOLD = IW'(HOLDOFF);

  typedef enum logic [2:0] {COLLECT, WAIT_SPACE, HDR, PAYLOAD, PAD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          dropped_q, dropped_d;
  logic          pend_q, pend_d;
  logic [7:0]    widx_q, widx_d;
  logic [31:0]   ts_q, ts_d;
  logic [15:0]   hdr_hi_q, hdr_hi_d;
  logic          en_q, en_d;
  logic          wr_q, wr_d;
  logic [15:0]   data_q, data_d;
  logic          end_q, end_d;

  logic [15:0]   buf_q [MAX_WORDS];
  logic          buf_we;
  logic [7:0]    pidx;
  logic [15:0]   word_sel;
  logic [15:0]   hdr_lo;

  assign rx_WR_enabled = en_q;
  assign out_wr        = wr_q;
  assign out_data      = data_q;
  assign out_pkt_end   = end_q;

  // Payload storage carries data only, so it is not reset.
  always_ff @(posedge txclk) begin
    if (buf_we) buf_q[count_q] <= rx_databus;
  end

  always_comb begin
    pidx     = widx_q - 8'd4;
    hdr_lo   = {7'b0, count_q, 1'b0};
    word_sel = 16'h0000;
    case (widx_q)
      8'd1:    word_sel = hdr_hi_q;
      8'd2:    word_sel = ts_q[15:0];
      8'd3:    word_sel = ts_q[31:16];
      default: if (widx_q >= 8'd4 && pidx < count_q) word_sel = buf_q[pidx];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idle_d    = idle_q;
    dropped_d = dropped_q;
    pend_d    = pend_q;
    widx_d    = widx_q;
    ts_d      = ts_q;
    hdr_hi_d  = hdr_hi_q;
    wr_d      = 1'b0;
    data_d    = 16'h0000;
    end_d     = 1'b0;
    buf_we    = 1'b0;

    case (state_q)
      COLLECT: begin
        if (rx_WR) begin
          idle_d = '0;
          if (count_q < MAXC) begin
            buf_we  = 1'b1;
            count_d = count_q + 8'd1;
            if (count_d == MAXC) state_d = WAIT_SPACE;
          end else begin
            dropped_d = 1'b1;
          end
        end else if (rx_WR_done && count_q != 8'd0) begin
          idle_d = idle_q + 1'b1;
          if (idle_d == HOLD) state_d = WAIT_SPACE;
        end else begin
          idle_d = '0;
        end
      end

      WAIT_SPACE: begin
        // Words arriving once collection has closed belong to the next packet's drop report.
        if (rx_WR) pend_d = 1'b1;
        if (out_have_space) begin
          ts_d     = adc_time;
          hdr_hi_d = {3'b000, 1'b1, 1'b1, 1'b0, dropped_q, 4'b0000, CHANNEL};
          wr_d     = 1'b1;
          data_d   = hdr_lo;
          widx_d   = 8'd1;
          state_d  = HDR;
        end
      end

      HDR, PAYLOAD, PAD: begin
        if (rx_WR) pend_d = 1'b1;
        wr_d   = 1'b1;
        data_d = word_sel;
        widx_d = widx_q + 8'd1;
        if (widx_q == 8'd255) begin
          end_d     = 1'b1;
          state_d   = COLLECT;
          count_d   = 8'd0;
          idle_d    = '0;
          dropped_d = pend_d;
          pend_d    = 1'b0;
          widx_d    = 8'd0;
        end else if (state_q == HDR && widx_q == 8'd3) begin
          state_d = PAYLOAD;
        end else if (state_q == PAYLOAD && 8'(pidx + 8'd1) == count_q) begin
          state_d = PAD;
        end
      end

      default: state_d = COLLECT;
    endcase

    // Two free slots are always guaranteed because the writer sends pairs unconditionally.
    en_d = (state_d == COLLECT) && (count_d <= MAXC - 8'd2);
  end

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      count_q   <= 8'd0;
      idle_q    <= '0;
      dropped_q <= 1'b0;
      pend_q    <= 1'b0;
      widx_q    <= 8'd0;
      ts_q      <= 32'd0;
      hdr_hi_q  <= 16'd0;
      en_q      <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= 16'd0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      dropped_q <= dropped_d;
      pend_q    <= pend_d;
      widx_q    <= widx_d;
      ts_q      <= ts_d;
      hdr_hi_q  <= hdr_hi_d;
      en_q      <= en_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      end_q     <= end_d;
    end
  end

endmodule
